// File: rtl/memcard_target.sv
// Memory-card command-line target: receives 48-bit host command frames and
// transmits 48-bit response frames on a shared CMD wire, controlled through a small CSR page.
//
// rx state | meaning
// RX_IDLE  | waiting for a start bit (CMD low on an mc_clk rise)
// RX_SHIFT | capturing frame bits on mc_clk rises
// RX_HOLD  | frame captured, parked until software clears rx_pending
//
// tx state | meaning
// TX_IDLE  | line released, ready for a TXIDX write
// TX_WAIT  | counting NCR mc_clk falls before the start bit
// TX_SHIFT | driving frame bits on mc_clk falls
module memcard_target #(
  parameter logic [3:0] csr_addr = 4'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq,
  input  logic        mc_clk,
  inout  wire         mc_cmd
);

  typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_HOLD} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SHIFT} tx_state_t;

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic d);
    logic fb;
    fb = c[6] ^ d;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_next(c, d[i]);
    return c;
  endfunction

  logic s0_clk, s1_clk, s2_clk, s0_cmd, s1_cmd, s2_cmd;
  logic rise, fall;

  logic        rx_enable, rx_pending, crc_err, frame_err;
  logic [6:0]  rx_idx, tx_idx;
  logic [31:0] rx_arg, tx_arg;
  logic [7:0]  ncr;

  rx_state_t   rx_state, rx_next;
  logic [46:0] rx_sh;
  logic [47:0] rx_frame;
  logic [5:0]  rx_cnt;
  logic [6:0]  rx_crc;
  logic        rx_start, rx_shift, rx_done;

  tx_state_t   tx_state, tx_next;
  logic [47:0] tx_sh;
  logic [5:0]  tx_cnt;
  logic [7:0]  tx_wait;
  logic        tx_oe, tx_out, tx_busy;
  logic        tx_load, tx_launch, tx_step, tx_end;

  logic csr_sel, ctrl_wr, txidx_wr;
  logic unused_addr;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      {s0_clk, s1_clk, s2_clk} <= '0;
      {s0_cmd, s1_cmd, s2_cmd} <= '0;
    end else begin
      {s0_clk, s1_clk, s2_clk} <= {mc_clk, s0_clk, s1_clk};
      {s0_cmd, s1_cmd, s2_cmd} <= {mc_cmd, s0_cmd, s1_cmd};
    end
  end

  assign rise        = s1_clk & ~s2_clk;
  assign fall        = ~s1_clk & s2_clk;
  assign csr_sel     = (csr_a[13:10] == csr_addr);
  assign ctrl_wr     = csr_sel && csr_we && (csr_a[2:0] == 3'd0);
  assign txidx_wr    = csr_sel && csr_we && (csr_a[2:0] == 3'd4);
  assign unused_addr = ^csr_a[9:3];
  assign tx_busy     = (tx_state != TX_IDLE);
  assign irq         = rx_pending;
  assign mc_cmd      = tx_oe ? tx_out : 1'bz;
  assign rx_frame    = {rx_sh, s2_cmd};

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  always_comb begin
    rx_next  = rx_state;
    rx_start = 1'b0;
    rx_shift = 1'b0;
    rx_done  = 1'b0;
    case (rx_state)
      RX_IDLE:
        if (rise && !s2_cmd && rx_enable && !tx_busy && !rx_pending) begin
          rx_next  = RX_SHIFT;
          rx_start = 1'b1;
        end
      RX_SHIFT:
        if (!rx_enable) begin
          rx_next = RX_IDLE;
        end else if (rise) begin
          rx_shift = 1'b1;
          if (rx_cnt == 6'd47) begin
            rx_done = 1'b1;
            rx_next = RX_HOLD;
          end
        end
      RX_HOLD:
        if (!rx_pending) rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    tx_next   = tx_state;
    tx_load   = 1'b0;
    tx_launch = 1'b0;
    tx_step   = 1'b0;
    tx_end    = 1'b0;
    case (tx_state)
      TX_IDLE:
        if (txidx_wr) begin
          tx_next = TX_WAIT;
          tx_load = 1'b1;
        end
      TX_WAIT:
        if (fall && tx_wait == 8'd0) begin
          tx_next   = TX_SHIFT;
          tx_launch = 1'b1;
        end
      TX_SHIFT:
        if (fall) begin
          if (tx_cnt == 6'd48) begin
            tx_next = TX_IDLE;
            tx_end  = 1'b1;
          end else begin
            tx_step = 1'b1;
          end
        end
      default: tx_next = TX_IDLE;
    endcase
  end

  // A frame completing on the same cycle as a CTRL clear takes priority.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_sh      <= '0;
      rx_cnt     <= '0;
      rx_crc     <= '0;
      rx_enable  <= 1'b0;
      rx_pending <= 1'b0;
      crc_err    <= 1'b0;
      frame_err  <= 1'b0;
      rx_idx     <= '0;
      rx_arg     <= '0;
    end else begin
      if (rx_start) begin
        rx_sh  <= '0;
        rx_cnt <= 6'd1;
        rx_crc <= '0;
      end else if (rx_shift) begin
        rx_sh  <= rx_frame[46:0];
        rx_cnt <= rx_cnt + 6'd1;
        if (rx_cnt < 6'd40) rx_crc <= crc7_next(rx_crc, s2_cmd);
      end
      if (rx_done) begin
        rx_pending <= 1'b1;
        rx_idx     <= rx_frame[46:40];
        rx_arg     <= rx_frame[39:8];
        crc_err    <= (rx_frame[7:1] != rx_crc);
        frame_err  <= !rx_frame[46] || !rx_frame[0];
      end else if (ctrl_wr && csr_di[1]) begin
        rx_pending <= 1'b0;
        crc_err    <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (ctrl_wr) rx_enable <= csr_di[0];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_sh   <= '0;
      tx_cnt  <= '0;
      tx_wait <= '0;
      tx_oe   <= 1'b0;
      tx_out  <= 1'b0;
      tx_arg  <= '0;
      tx_idx  <= '0;
      ncr     <= 8'd2;
    end else begin
      if (csr_sel && csr_we && csr_a[2:0] == 3'd3) tx_arg <= csr_di;
      if (csr_sel && csr_we && csr_a[2:0] == 3'd5) ncr <= csr_di[7:0];
      if (tx_load) begin
        tx_idx  <= csr_di[6:0];
        tx_sh   <= {1'b0, csr_di[6:0], tx_arg, crc7_40({1'b0, csr_di[6:0], tx_arg}), 1'b1};
        tx_wait <= ncr;
      end else if (tx_state == TX_WAIT && fall && tx_wait != 8'd0) begin
        tx_wait <= tx_wait - 8'd1;
      end
      if (tx_launch || tx_step) begin
        tx_out <= tx_sh[47];
        tx_sh  <= {tx_sh[46:0], 1'b0};
        tx_cnt <= tx_launch ? 6'd1 : tx_cnt + 6'd1;
        tx_oe  <= 1'b1;
      end
      if (tx_end) tx_oe <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      csr_do <= '0;
    end else begin
      csr_do <= '0;
      if (csr_sel) begin
        case (csr_a[2:0])
          3'd0: csr_do <= {27'd0, tx_busy, frame_err, crc_err, rx_pending, rx_enable};
          3'd1: csr_do <= {25'd0, rx_idx};
          3'd2: csr_do <= rx_arg;
          3'd3: csr_do <= tx_arg;
          3'd4: csr_do <= {25'd0, tx_idx};
          3'd5: csr_do <= {24'd0, ncr};
          default: csr_do <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_memcard_target.sv
// Directed bench for memcard_target: host-side frame driver, CSR access and
// wire capture of transmitted frames, with hand-computed expectations.
module tb_memcard_target;

  localparam logic [3:0] PAGE    = 4'h3;
  localparam logic [2:0] R_CTRL  = 3'd0;
  localparam logic [2:0] R_RXIDX = 3'd1;
  localparam logic [2:0] R_RXARG = 3'd2;
  localparam logic [2:0] R_TXARG = 3'd3;
  localparam logic [2:0] R_TXIDX = 3'd4;
  localparam logic [2:0] R_NCR   = 3'd5;

  localparam logic [47:0] CMD0     = 48'h400000000095;
  localparam logic [47:0] CMD8     = 48'h48000001AA87;
  localparam logic [47:0] CMD8_END = 48'h48000001AA86;
  localparam logic [47:0] CMD8_CRC = 48'h48000001AA85;
  localparam logic [47:0] TX_EXP   = 48'h08000001AA13;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        irq;
  logic        mc_clk;
  logic        host_oe, host_bit;
  wire         mc_cmd;

  int n_checks = 0;
  int n_errors = 0;

  assign mc_cmd = host_oe ? host_bit : 1'bz;
  pullup (mc_cmd);

  always #5 sys_clk = ~sys_clk;

  memcard_target #(.csr_addr(PAGE)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .csr_a   (csr_a),
    .csr_we  (csr_we),
    .csr_di  (csr_di),
    .csr_do  (csr_do),
    .irq     (irq),
    .mc_clk  (mc_clk),
    .mc_cmd  (mc_cmd)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic csr_wr(input logic [2:0] r, input logic [31:0] d);
    csr_a  = {PAGE, 7'd0, r};
    csr_di = d;
    csr_we = 1'b1;
    @(negedge sys_clk);
    csr_we = 1'b0;
  endtask

  task automatic csr_rd_raw(input logic [13:0] a, output logic [31:0] d);
    csr_a  = a;
    csr_we = 1'b0;
    @(negedge sys_clk);
    d = csr_do;
  endtask

  task automatic csr_rd(input logic [2:0] r, output logic [31:0] d);
    csr_rd_raw({PAGE, 7'd0, r}, d);
  endtask

  // One mc_clk period; line/oe are sampled at the end of the low phase.
  // With clr set, a CTRL clear is issued on the cycle the rise takes effect.
  task automatic mc_tick(input logic drv, input logic b, input logic clr,
                         output logic line, output logic oe);
    mc_clk   = 1'b0;
    host_oe  = drv;
    host_bit = b;
    repeat (6) @(negedge sys_clk);
    line   = mc_cmd;
    oe     = dut.tx_oe;
    mc_clk = 1'b1;
    if (clr) begin
      repeat (2) @(negedge sys_clk);
      csr_wr(R_CTRL, 32'h3);
      repeat (3) @(negedge sys_clk);
    end else begin
      repeat (6) @(negedge sys_clk);
    end
  endtask

  task automatic host_send(input logic [47:0] f, input logic clr_last);
    logic l, o;
    for (int i = 47; i >= 0; i--) mc_tick(1'b1, f[i], clr_last && (i == 0), l, o);
    host_oe = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [47:0] wire_bits;
    logic        l, o, oe_pre, oe_all, oe_end;

    sys_rst = 1'b1; csr_we = 1'b0; csr_a = '0; csr_di = '0;
    mc_clk = 1'b1; host_oe = 1'b0; host_bit = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    check("rst_irq", irq, 0);
    csr_rd(R_CTRL, d);  check("rst_ctrl", d, 0);
    csr_rd(R_NCR, d);   check("rst_ncr", d, 2);
    csr_rd(R_TXIDX, d); check("rst_txidx", d, 0);
    csr_rd(R_RXARG, d); check("rst_rxarg", d, 0);

    csr_wr(R_CTRL, 32'h1);
    host_send(CMD0, 1'b0);
    check("cmd0_irq", irq, 1);
    csr_rd(R_RXIDX, d); check("cmd0_rxidx", d, 32'h40);
    csr_rd(R_RXARG, d); check("cmd0_rxarg", d, 0);
    csr_rd(R_CTRL, d);  check("cmd0_ctrl", d, 32'h3);

    host_send(CMD8, 1'b0);
    csr_rd(R_RXIDX, d); check("pending_blocks_rx", d, 32'h40);
    csr_wr(R_CTRL, 32'h3);
    check("clear_irq", irq, 0);
    csr_rd(R_CTRL, d);  check("clear_ctrl", d, 32'h1);

    host_send(CMD8, 1'b0);
    csr_rd(R_RXIDX, d); check("cmd8_rxidx", d, 32'h48);
    csr_rd(R_RXARG, d); check("cmd8_rxarg", d, 32'h1AA);
    csr_rd(R_CTRL, d);  check("cmd8_ctrl", d, 32'h3);
    csr_rd_raw({4'h5, 7'd0, R_RXARG}, d); check("other_page", d, 0);
    csr_rd_raw({PAGE, 7'd0, 3'd6}, d);    check("unmapped", d, 0);

    csr_wr(R_CTRL, 32'h3);
    host_send(CMD8_END, 1'b0);
    csr_rd(R_CTRL, d);  check("end_bit_frame_err", d[3], 1);
    csr_rd(R_RXARG, d); check("end_bit_rxarg", d, 32'h1AA);

    csr_wr(R_CTRL, 32'h3);
    host_send(CMD8_CRC, 1'b0);
    csr_rd(R_CTRL, d);  check("bad_crc_ctrl", d, 32'h7);

    csr_wr(R_CTRL, 32'h3);
    for (int i = 47; i >= 28; i--) mc_tick(1'b1, CMD0[i], 1'b0, l, o);
    csr_wr(R_CTRL, 32'h0);
    for (int i = 27; i >= 0; i--) mc_tick(1'b1, CMD0[i], 1'b0, l, o);
    host_oe = 1'b0;
    csr_rd(R_CTRL, d);  check("abort_ctrl", d, 0);
    check("abort_irq", irq, 0);
    csr_wr(R_CTRL, 32'h1);
    host_send(CMD0, 1'b0);
    csr_rd(R_RXIDX, d); check("after_abort_rxidx", d, 32'h40);
    csr_rd(R_CTRL, d);  check("after_abort_ctrl", d, 32'h3);

    csr_wr(R_CTRL, 32'h3);
    host_send(CMD8, 1'b1);
    check("race_irq", irq, 1);
    csr_rd(R_RXIDX, d); check("race_rxidx", d, 32'h48);
    csr_rd(R_CTRL, d);  check("race_ctrl", d, 32'h3);

    csr_wr(R_CTRL, 32'h3);
    csr_wr(R_TXARG, 32'h1AA);
    csr_rd(R_TXARG, d); check("txarg_rw", d, 32'h1AA);
    csr_wr(R_TXIDX, 32'h08);
    csr_wr(R_TXIDX, 32'h55);
    csr_rd(R_TXIDX, d); check("txidx_busy_ignore", d, 32'h08);
    csr_rd(R_CTRL, d);  check("tx_busy_set", d, 32'h11);
    oe_pre = 1'b0; oe_all = 1'b1; oe_end = 1'b1; wire_bits = '0;
    for (int k = 1; k <= 51; k++) begin
      mc_tick(1'b0, 1'b1, 1'b0, l, o);
      if (k <= 2) oe_pre = oe_pre | o;
      else if (k <= 50) begin
        wire_bits = {wire_bits[46:0], l};
        oe_all = oe_all & o;
      end else oe_end = o;
    end
    check("tx_oe_before_start", oe_pre, 0);
    check("tx_oe_during", oe_all, 1);
    check("tx_wire", wire_bits, TX_EXP);
    check("tx_oe_after", oe_end, 0);
    csr_rd(R_CTRL, d);  check("tx_done_ctrl", d, 32'h1);
    check("tx_no_self_rx", irq, 0);

    csr_wr(R_NCR, 32'h0);
    csr_rd(R_NCR, d);   check("ncr_rw", d, 0);
    csr_wr(R_TXIDX, 32'h40);
    mc_tick(1'b0, 1'b1, 1'b0, l, o);
    check("ncr0_oe", o, 1);
    check("ncr0_start", l, 0);
    for (int k = 2; k <= 49; k++) mc_tick(1'b0, 1'b1, 1'b0, l, o);
    csr_rd(R_CTRL, d);  check("ncr0_done", d, 32'h1);

    csr_wr(R_NCR, 32'd60);
    csr_wr(R_TXIDX, 32'h48);
    for (int k = 1; k <= 48; k++) mc_tick(1'b1, CMD0[48-k], 1'b0, l, o);
    host_oe = 1'b0;
    check("rx_blocked_by_tx_irq", irq, 0);
    csr_rd(R_RXIDX, d); check("rx_blocked_by_tx_idx", d, 32'h48);
    csr_rd(R_CTRL, d);  check("wait_ctrl", d, 32'h11);
    for (int k = 49; k <= 80; k++) mc_tick(1'b0, 1'b1, 1'b0, l, o);
    check("bit20_oe", o, 1);

    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("rst_mid_tx_oe", dut.tx_oe, 0);
    check("rst_mid_tx_line", mc_cmd, 1);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    csr_rd(R_CTRL, d);  check("rst_mid_tx_ctrl", d, 0);
    csr_rd(R_NCR, d);   check("rst_mid_tx_ncr", d, 2);
    csr_rd(R_TXIDX, d); check("rst_mid_tx_txidx", d, 0);
    check("rst_mid_tx_irq", irq, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
